// File: rtl/m_mem_arbiter.sv
// Two-requester arbiter (instruction fetch, load/store data) in front of one
// single-port synchronous-read memory; the read response is routed back one cycle later.
module m_mem_arbiter #(
    parameter int RR    = 1,
    parameter int CNT_W = 16
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_if_req,
    input  logic [31:0]      w_if_adr,
    output logic             w_if_gnt,
    output logic             w_if_rvalid,
    output logic [31:0]      w_if_rdata,
    input  logic             w_d_req,
    input  logic             w_d_we,
    input  logic [31:0]      w_d_adr,
    input  logic [31:0]      w_d_wd,
    output logic             w_d_gnt,
    output logic             w_d_rvalid,
    output logic [31:0]      w_d_rdata,
    output logic             w_m_en,
    output logic             w_m_we,
    output logic [31:0]      w_m_adr,
    output logic [31:0]      w_m_wd,
    input  logic [31:0]      w_m_rd,
    output logic [CNT_W-1:0] w_conflicts
);

    typedef enum logic {
        PORT_IF,
        PORT_D
    } port_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_t;

    port_t            last_reg;
    owner_t           owner_reg;
    logic [CNT_W-1:0] conflicts_reg;
    logic             both_req;
    logic             d_wins;

    assign both_req = w_if_req & w_d_req;

    // On conflict the data port wins unless round-robin says fetch's turn has come.
    assign d_wins = (RR != 0) ? (last_reg == PORT_IF) : 1'b1;

    // Grants are gated by reset so nothing reaches memory while reset is held.
    assign w_d_gnt  = ~w_rst & w_d_req  & (~w_if_req | d_wins);
    assign w_if_gnt = ~w_rst & w_if_req & ~(w_d_req & d_wins);

    assign w_m_en  = w_if_gnt | w_d_gnt;
    assign w_m_we  = w_d_gnt & w_d_we;
    assign w_m_adr = w_d_gnt ? w_d_adr : (w_if_gnt ? w_if_adr : 32'h0);
    assign w_m_wd  = w_m_we ? w_d_wd : 32'h0;

    assign w_if_rvalid = (owner_reg == OWN_IF);
    assign w_d_rvalid  = (owner_reg == OWN_D);
    assign w_if_rdata  = w_m_rd;
    assign w_d_rdata   = w_m_rd;
    assign w_conflicts = conflicts_reg;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            last_reg      <= PORT_IF;
            owner_reg     <= OWN_NONE;
            conflicts_reg <= '0;
        end else begin
            if (w_d_gnt) begin
                last_reg <= PORT_D;
            end else if (w_if_gnt) begin
                last_reg <= PORT_IF;
            end

            // Stores produce no response, so they leave the owner empty.
            if (w_if_gnt) begin
                owner_reg <= OWN_IF;
            end else if (w_d_gnt && !w_d_we) begin
                owner_reg <= OWN_D;
            end else begin
                owner_reg <= OWN_NONE;
            end

            if (both_req && (conflicts_reg != {CNT_W{1'b1}})) begin
                conflicts_reg <= conflicts_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Scoreboarded bench: three arbiter variants (RR=1, RR=0, RR=1 with a 2-bit counter)
// share one stimulus stream; each has its own behavioural memory.
module tb_m_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_adr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_adr;
    logic [31:0] d_wd;

    logic [2:0]       if_gnt, if_rvalid, d_gnt, d_rvalid, m_en, m_we;
    logic [2:0][31:0] if_rdata, d_rdata, m_adr, m_wd, m_rd;
    logic [15:0]      conf_rr;
    logic [15:0]      conf_fp;
    logic [1:0]       conf_sat;

    logic [31:0] mem [3][64];

    logic [31:0] exp_if_q[$];
    logic [31:0] exp_d_q[$];
    int n_pass;
    int n_total;

    m_mem_arbiter #(.RR(1), .CNT_W(16)) dut (
        .w_clk(clk), .w_rst(rst),
        .w_if_req(if_req), .w_if_adr(if_adr), .w_if_gnt(if_gnt[0]),
        .w_if_rvalid(if_rvalid[0]), .w_if_rdata(if_rdata[0]),
        .w_d_req(d_req), .w_d_we(d_we), .w_d_adr(d_adr), .w_d_wd(d_wd),
        .w_d_gnt(d_gnt[0]), .w_d_rvalid(d_rvalid[0]), .w_d_rdata(d_rdata[0]),
        .w_m_en(m_en[0]), .w_m_we(m_we[0]), .w_m_adr(m_adr[0]), .w_m_wd(m_wd[0]),
        .w_m_rd(m_rd[0]), .w_conflicts(conf_rr)
    );

    m_mem_arbiter #(.RR(0), .CNT_W(16)) dut_fp (
        .w_clk(clk), .w_rst(rst),
        .w_if_req(if_req), .w_if_adr(if_adr), .w_if_gnt(if_gnt[1]),
        .w_if_rvalid(if_rvalid[1]), .w_if_rdata(if_rdata[1]),
        .w_d_req(d_req), .w_d_we(d_we), .w_d_adr(d_adr), .w_d_wd(d_wd),
        .w_d_gnt(d_gnt[1]), .w_d_rvalid(d_rvalid[1]), .w_d_rdata(d_rdata[1]),
        .w_m_en(m_en[1]), .w_m_we(m_we[1]), .w_m_adr(m_adr[1]), .w_m_wd(m_wd[1]),
        .w_m_rd(m_rd[1]), .w_conflicts(conf_fp)
    );

    m_mem_arbiter #(.RR(1), .CNT_W(2)) dut_sat (
        .w_clk(clk), .w_rst(rst),
        .w_if_req(if_req), .w_if_adr(if_adr), .w_if_gnt(if_gnt[2]),
        .w_if_rvalid(if_rvalid[2]), .w_if_rdata(if_rdata[2]),
        .w_d_req(d_req), .w_d_we(d_we), .w_d_adr(d_adr), .w_d_wd(d_wd),
        .w_d_gnt(d_gnt[2]), .w_d_rvalid(d_rvalid[2]), .w_d_rdata(d_rdata[2]),
        .w_m_en(m_en[2]), .w_m_we(m_we[2]), .w_m_adr(m_adr[2]), .w_m_wd(m_wd[2]),
        .w_m_rd(m_rd[2]), .w_conflicts(conf_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory models, one per arbiter; read data registered.
    initial begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 64; i++) mem[k][i] = 32'hA000_0000 | i;
            mem[k][4] = 32'hDEAD_BEEF;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (m_en[k]) begin
                if (m_we[k]) mem[k][m_adr[k][7:2]] <= m_wd[k];
                else         m_rd[k] <= mem[k][m_adr[k][7:2]];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr,
                          input logic dw, input logic [31:0] da, input logic [31:0] dd);
        if_req = ir; if_adr = ia; d_req = dr; d_we = dw; d_adr = da; d_wd = dd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b0;
    endtask

    // Monitor: every presented response must match the head of its queue.
    always @(negedge clk) begin
        if (if_rvalid[0]) begin
            if (exp_if_q.size() == 0) begin
                n_total++;
                $display("FAIL if_rvalid_unexpected: got rvalid=1 expected 0 (t=%0t)", $time);
            end else begin
                check("if_rdata", if_rdata[0], exp_if_q.pop_front());
                $display("fetch resp rdata=0x%08h", if_rdata[0]);
            end
        end
        if (d_rvalid[0]) begin
            if (exp_d_q.size() == 0) begin
                n_total++;
                $display("FAIL d_rvalid_unexpected: got rvalid=1 expected 0 (t=%0t)", $time);
            end else begin
                check("d_rdata", d_rdata[0], exp_d_q.pop_front());
                $display("data resp rdata=0x%08h", d_rdata[0]);
            end
        end
    end

    logic [1:0] sat_exp [6];

    initial begin
        n_pass = 0;
        n_total = 0;
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #2;
        check("rst_if_gnt", {31'b0, if_gnt[0]}, 32'd0);
        check("rst_d_gnt", {31'b0, d_gnt[0]}, 32'd0);
        check("rst_m_en", {31'b0, m_en[0]}, 32'd0);
        check("rst_m_adr", m_adr[0], 32'd0);
        check("rst_rvalid", {30'b0, if_rvalid[0], d_rvalid[0]}, 32'd0);
        check("rst_conflicts", {16'b0, conf_rr}, 32'd0);
        next_cycle();
        rst = 1'b0;

        // Fetch only
        set_in(1, 32'h10, 0, 0, 0, 0);
        exp_if_q.push_back(32'hDEAD_BEEF);
        #3;
        check("fetch_if_gnt", {31'b0, if_gnt[0]}, 32'd1);
        check("fetch_d_gnt", {31'b0, d_gnt[0]}, 32'd0);
        check("fetch_m_en_we", {30'b0, m_en[0], m_we[0]}, 32'd2);
        check("fetch_m_adr", m_adr[0], 32'h10);
        $display("fetch req adr=0x10 gnt=%0d", if_gnt[0]);
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0);
        #3;
        check("idle_m_en", {31'b0, m_en[0]}, 32'd0);
        next_cycle();

        // Store then load
        set_in(0, 0, 1, 1, 32'h20, 32'h1234);
        #3;
        check("store_d_gnt", {31'b0, d_gnt[0]}, 32'd1);
        check("store_m_we", {31'b0, m_we[0]}, 32'd1);
        check("store_m_adr", m_adr[0], 32'h20);
        check("store_m_wd", m_wd[0], 32'h1234);
        $display("store adr=0x20 wd=0x1234 gnt=%0d", d_gnt[0]);
        next_cycle();
        set_in(0, 0, 1, 0, 32'h20, 0);
        exp_d_q.push_back(32'h1234);
        #3;
        check("store_no_rvalid", {31'b0, d_rvalid[0]}, 32'd0);
        check("load_d_gnt", {31'b0, d_gnt[0]}, 32'd1);
        check("load_m_we", {31'b0, m_we[0]}, 32'd0);
        $display("load adr=0x20 gnt=%0d", d_gnt[0]);
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0);
        next_cycle();

        // Sustained dual requests: RR alternates D,IF,...; fixed priority keeps D
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            set_in(1, 32'h18, 1, 0, 32'h1C, 0);
            if (i % 2 == 1) exp_d_q.push_back(32'hA000_0007);
            else            exp_if_q.push_back(32'hA000_0006);
            #3;
            check("rr_d_gnt", {31'b0, d_gnt[0]}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("rr_if_gnt", {31'b0, if_gnt[0]}, (i % 2 == 1) ? 32'd0 : 32'd1);
            check("fp_gnt", {30'b0, d_gnt[1], if_gnt[1]}, 32'd2);
            $display("dual req cycle %0d: rr d/if=%0d/%0d fp d/if=%0d/%0d",
                     i, d_gnt[0], if_gnt[0], d_gnt[1], if_gnt[1]);
            next_cycle();
            check("rr_conflicts", {16'b0, conf_rr}, i);
            check("sat_conflicts", {30'b0, conf_sat}, {30'b0, sat_exp[i-1]});
        end
        set_in(1, 32'h18, 0, 0, 0, 0);
        exp_if_q.push_back(32'hA000_0006);
        #3;
        check("fp_if_after_drop", {31'b0, if_gnt[1]}, 32'd1);
        check("rr_if_after_drop", {31'b0, if_gnt[0]}, 32'd1);
        $display("fetch after data drop: fp if_gnt=%0d", if_gnt[1]);
        next_cycle();

        // Reset with a load in flight
        set_in(0, 0, 1, 0, 32'h10, 0);
        #3;
        check("inflight_d_gnt", {31'b0, d_gnt[0]}, 32'd1);
        next_cycle();
        check("pre_rst_conflicts", {16'b0, conf_rr}, 32'd6);
        check("pre_rst_d_rvalid", {31'b0, d_rvalid[0]}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid", {30'b0, if_rvalid[0], d_rvalid[0]}, 32'd0);
        check("mid_rst_conflicts", {16'b0, conf_rr}, 32'd0);
        check("mid_rst_m_en", {31'b0, m_en[0]}, 32'd0);
        check("mid_rst_d_gnt", {31'b0, d_gnt[0]}, 32'd0);
        $display("reset mid-load: rvalid=%0d m_en=%0d", d_rvalid[0], m_en[0]);
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        next_cycle();
        next_cycle();

        check("if_queue_drained", exp_if_q.size(), 32'd0);
        check("d_queue_drained", exp_d_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
